hram_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single hyper_xface HyperRAM controller between two requesters: port 0 is the UART command path, port 1 is a memory-test/streaming engine. It accepts one single-dword command at a time and pulses rd_req or wr_req for exactly one cycle. It tracks controller busy/rd_rdy to completion and returns read data, or a timeout error, to the granted port. It sits between the top-level command logic and hyper_xface, replacing direct drive of rd_req/wr_req/addr/wr_d.

---
 rtl/hram_pkg.sv | 17 +
 rtl/hram_rr_arb2.sv | 32 +++
 rtl/hram_arbiter.sv | 156 +++++++++++++++
 tb/tb_hram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hram_pkg.sv
// Shared constants for the HyperRAM two-port arbiter.
package hram_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    // Every command is a single dword
    localparam logic [5:0] RD_NUM_DWORDS = 6'h1;

    // Byte enables presented to the controller out of reset
    localparam logic [3:0] DEF_BE = 4'hF;

endpackage

// File: rtl/hram_rr_arb2.sv
// Two-input round-robin grant. last_grant starts at 1 so port 0 wins the first tie.
module hram_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Combinational grant: lone requester wins, ties go to the port not granted last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Remember which port won whenever a grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (adv_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/hram_arbiter.sv
// Two-port arbiter/sequencer in front of hyper_xface: one single-dword command
// at a time, one-cycle request pulse, completion or timeout back to the owner.
module hram_arbiter
    import hram_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter int BUSY_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic        p0_reg,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic        p1_reg,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        x_rd_req,
    output logic        x_wr_req,
    output logic [31:0] x_addr,
    output logic [31:0] x_wr_d,
    output logic [3:0]  x_wr_byte_en,
    output logic [5:0]  x_rd_num_dwords,
    output logic        x_mem_or_reg,
    input  logic        x_busy,
    input  logic        x_rd_rdy,
    input  logic [31:0] x_rd_d,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt;
    logic          accept;
    logic          in_wait;
    logic          to_hit, bw_hit, tmo_fire, cap;
    logic          port_q, we_q, reg_q, err_q;
    logic [31:0]   addr_q, wd_q, rdata_q;
    logic [3:0]    be_q;

    hram_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({p1_valid, p0_valid}),
        .adv_i (state_q == ST_IDLE),
        .gnt_o (gnt)
    );

    assign accept  = (state_q == ST_IDLE) && (|gnt);
    assign in_wait = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

    // Wait-cycle counter: cleared while the pulse goes out, counts in the wait states
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE)
            cnt_d = '0;
        else if (in_wait)
            cnt_d = cnt_q + CW'(1);
    end

    // cnt_d is the number of wait cycles elapsed, including the current one
    assign to_hit   = in_wait && (cnt_d == CW'(TIMEOUT - 1));
    assign bw_hit   = (state_q == ST_WAIT_BUSY) && (cnt_d == CW'(BUSY_WAIT));
    assign tmo_fire = to_hit && ((state_q == ST_WAIT_BUSY) || x_busy);
    assign cap      = in_wait && x_rd_rdy && !we_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (to_hit)      state_d = ST_RESP;
                else if (x_busy) state_d = ST_WAIT_DONE;
                else if (bw_hit) state_d = ST_RESP;
            end
            ST_WAIT_DONE: if (!x_busy || to_hit) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: ready only in IDLE, pulses only in ISSUE
    always_comb begin
        p0_ready  = accept && gnt[0];
        p1_ready  = accept && gnt[1];
        x_wr_req  = (state_q == ST_ISSUE) && we_q;
        x_rd_req  = (state_q == ST_ISSUE) && !we_q;
        p0_rvalid = (state_q == ST_RESP) && !port_q;
        p1_rvalid = (state_q == ST_RESP) && port_q;
        busy      = (state_q != ST_IDLE);
    end

    // Command latch, read-data capture and timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            reg_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= DEF_BE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                port_q  <= gnt[1];
                we_q    <= gnt[1] ? p1_we    : p0_we;
                reg_q   <= gnt[1] ? p1_reg   : p0_reg;
                addr_q  <= gnt[1] ? p1_addr  : p0_addr;
                wd_q    <= gnt[1] ? p1_wdata : p0_wdata;
                be_q    <= gnt[1] ? p1_be    : p0_be;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else begin
                if (cap)      rdata_q <= x_rd_d;
                if (tmo_fire) err_q   <= 1'b1;
            end
        end
    end

    assign x_addr          = addr_q;
    assign x_wr_d          = wd_q;
    assign x_wr_byte_en    = be_q;
    assign x_mem_or_reg    = reg_q;
    assign x_rd_num_dwords = RD_NUM_DWORDS;
    assign p0_rdata        = rdata_q;
    assign p1_rdata        = rdata_q;
    assign p0_err          = err_q;
    assign p1_err          = err_q;

endmodule

// File: tb/tb_hram_arbiter.sv
// Scoreboard bench for hram_arbiter with a small hyper_xface behaviour model.
module tb_hram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_reg, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_valid, p1_ready, p1_we, p1_reg, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        x_rd_req, x_wr_req, x_mem_or_reg, x_busy, x_rd_rdy, busy;
    logic [31:0] x_addr, x_wr_d, x_rd_d;
    logic [3:0]  x_wr_byte_en;
    logic [5:0]  x_rd_num_dwords;

    typedef struct {logic we; logic rg; logic [31:0] addr; logic [31:0] wd; logic [3:0] be;} req_t;
    typedef struct {int port; logic [31:0] rdata; logic err; int lat;} rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   exp_gnt[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    int mode = 0;      // 0: busy for busy_len, 1: read data at cycle 15, 2: busy until rel_busy, 3: never busy
    int busy_len = 20;
    int rel_busy = 0;

    hram_arbiter #(.TIMEOUT(64), .BUSY_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_reg(p0_reg),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_reg(p1_reg),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .x_rd_req(x_rd_req), .x_wr_req(x_wr_req), .x_addr(x_addr), .x_wr_d(x_wr_d),
        .x_wr_byte_en(x_wr_byte_en), .x_rd_num_dwords(x_rd_num_dwords),
        .x_mem_or_reg(x_mem_or_reg), .x_busy(x_busy), .x_rd_rdy(x_rd_rdy),
        .x_rd_d(x_rd_d), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  {p1_ready, p0_ready}, 0);
        chk({tag, "_rvalid"}, {p1_rvalid, p0_rvalid}, 0);
        chk({tag, "_err"},    {p1_err, p0_err}, 0);
        chk({tag, "_reqs"},   {x_rd_req, x_wr_req}, 0);
        chk({tag, "_addr"},   x_addr, 0);
        chk({tag, "_wr_d"},   x_wr_d, 0);
        chk({tag, "_be"},     x_wr_byte_en, 32'hF);
        chk({tag, "_mor"},    x_mem_or_reg, 0);
        chk({tag, "_rdata0"}, p0_rdata, 0);
        chk({tag, "_rdata1"}, p1_rdata, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_ndw"},    x_rd_num_dwords, 1);
    endtask

    function automatic void expect_cmd(input int p, input logic we, input logic rg,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] be);
        req_t r;
        r.we = we; r.rg = rg; r.addr = a; r.wd = d; r.be = be;
        exp_req.push_back(r);
        exp_gnt.push_back(p);
    endfunction

    function automatic void expect_rsp(input int p, input logic [31:0] rd, input logic e, input int lat);
        rsp_t s;
        s.port = p; s.rdata = rd; s.err = e; s.lat = lat;
        exp_rsp.push_back(s);
    endfunction

    task automatic send(input int p, input logic we, input logic rg, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int n;
        @(negedge clk);
        if (p == 0) begin
            p0_valid = 1; p0_we = we; p0_reg = rg; p0_addr = a; p0_wdata = d; p0_be = be;
        end else begin
            p1_valid = 1; p1_we = we; p1_reg = rg; p1_addr = a; p1_wdata = d; p1_be = be;
        end
        n = 0;
        #1;
        while (!((p == 0) ? p0_ready : p1_ready) && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_wait", (n < 3000), 1);
        @(negedge clk);
        if (p == 0) p0_valid = 0; else p1_valid = 0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("rsp_wait", exp_rsp.size(), 0);
    endtask

    // Controller model: checks each request pulse, then plays the selected busy/rd_rdy pattern
    initial begin
        req_t r;
        x_busy = 0; x_rd_rdy = 0; x_rd_d = 0;
        forever begin
            @(negedge clk); #1;
            if (x_rd_req || x_wr_req) begin
                pulse_cyc = cyc;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", exp_req.size(), 1);
                end else begin
                    r = exp_req.pop_front();
                    chk("x_wr_req", x_wr_req, r.we);
                    chk("x_rd_req", x_rd_req, !r.we);
                    chk("x_addr", x_addr, r.addr);
                    chk("x_wr_d", x_wr_d, r.wd);
                    chk("x_be", x_wr_byte_en, r.be);
                    chk("x_mor", x_mem_or_reg, r.rg);
                end
                if (mode != 3) x_busy = 1;
                @(negedge clk); #1;
                chk("pulse_width", {x_rd_req, x_wr_req}, 0);
                case (mode)
                    0: begin
                        repeat (busy_len - 1) @(negedge clk);
                        #1 x_busy = 0;
                    end
                    1: begin
                        repeat (14) @(negedge clk);
                        #1;
                        x_busy = 0; x_rd_rdy = 1; x_rd_d = 32'hDEADBEEF;
                        @(negedge clk);
                        #1;
                        x_rd_rdy = 0; x_rd_d = 0;
                    end
                    2: begin
                        while (rel_busy == 0) @(negedge clk);
                        #1 x_busy = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: grants and responses against the scoreboard queues
    initial begin
        rsp_t s;
        int gp;
        forever begin
            @(negedge clk); #2;
            if (p0_ready || p1_ready) begin
                gp = p1_ready ? 1 : 0;
                chk("ready_excl", {p1_ready, p0_ready} == 2'b11, 0);
                if (exp_gnt.size() == 0) chk("grant_unexpected", exp_gnt.size(), 1);
                else chk("grant_port", gp, exp_gnt.pop_front());
            end
            if (p0_rvalid || p1_rvalid) begin
                chk("rvalid_excl", {p1_rvalid, p0_rvalid} == 2'b11, 0);
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", exp_rsp.size(), 1);
                end else begin
                    s = exp_rsp.pop_front();
                    chk("rsp_port", p1_rvalid ? 1 : 0, s.port);
                    chk("rsp_rdata", p1_rvalid ? p1_rdata : p0_rdata, s.rdata);
                    chk("rsp_err", p1_rvalid ? p1_err : p0_err, s.err);
                    if (s.lat >= 0) chk("rsp_latency", cyc - pulse_cyc, s.lat);
                end
            end
        end
    end

    initial begin
        reset = 1;
        p0_valid = 0; p0_we = 0; p0_reg = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
        p1_valid = 0; p1_we = 0; p1_reg = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 0;

        // p0 write, controller busy 20 cycles
        mode = 0; busy_len = 20;
        expect_cmd(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
        expect_rsp(0, 32'h0, 0, -1);
        send(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_rsp();

        // p1 read, data arrives as busy falls at cycle 15
        mode = 1;
        expect_cmd(1, 0, 0, 32'h10, 32'h0, 4'hF);
        expect_rsp(1, 32'hDEADBEEF, 0, 16);
        send(1, 0, 0, 32'h10, 32'h0, 4'hF);
        wait_rsp();

        // both ports hammering: p0, p1, p0, p1
        mode = 0; busy_len = 3;
        expect_cmd(0, 1, 0, 32'h100, 32'h11111111, 4'h3);
        expect_cmd(1, 1, 1, 32'h20,  32'h22222222, 4'hC);
        expect_cmd(0, 0, 0, 32'h104, 32'h0, 4'hF);
        expect_cmd(1, 0, 1, 32'h24,  32'h0, 4'hF);
        expect_rsp(0, 0, 0, -1);
        expect_rsp(1, 0, 0, -1);
        expect_rsp(0, 0, 0, -1);
        expect_rsp(1, 0, 0, -1);
        fork
            begin
                send(0, 1, 0, 32'h100, 32'h11111111, 4'h3);
                send(0, 0, 0, 32'h104, 32'h0, 4'hF);
            end
            begin
                send(1, 1, 1, 32'h20, 32'h22222222, 4'hC);
                send(1, 0, 1, 32'h24, 32'h0, 4'hF);
            end
        join
        wait_rsp();

        // busy never drops: timeout 64 cycles after the pulse
        mode = 2;
        expect_cmd(0, 0, 0, 32'h200, 32'h0, 4'hF);
        expect_rsp(0, 0, 1, 64);
        send(0, 0, 0, 32'h200, 32'h0, 4'hF);
        wait_rsp();
        rel_busy = 1;
        repeat (2) @(negedge clk);
        rel_busy = 0;

        // next command after the timeout still proceeds
        mode = 0; busy_len = 2;
        expect_cmd(1, 1, 0, 32'h300, 32'hCAFEF00D, 4'h5);
        expect_rsp(1, 0, 0, -1);
        send(1, 1, 0, 32'h300, 32'hCAFEF00D, 4'h5);
        wait_rsp();

        // busy never rises: done five cycles after the pulse
        mode = 3;
        expect_cmd(1, 0, 0, 32'h400, 32'h0, 4'hF);
        expect_rsp(1, 0, 0, 5);
        send(1, 0, 0, 32'h400, 32'h0, 4'hF);
        wait_rsp();
        expect_cmd(0, 1, 1, 32'h404, 32'h12345678, 4'h8);
        expect_rsp(0, 0, 0, 5);
        send(0, 1, 1, 32'h404, 32'h12345678, 4'h8);
        wait_rsp();

        // reset in WAIT_DONE: asynchronous clear, no response, p0 wins next tie
        mode = 2;
        expect_cmd(0, 0, 1, 32'h500, 32'hA5A5A5A5, 4'h1);
        send(0, 0, 1, 32'h500, 32'hA5A5A5A5, 4'h1);
        repeat (8) @(negedge clk);
        chk("busy_pre_reset", busy, 1);
        #2 reset = 1;
        #1 chk_reset_vals("midrst");
        rel_busy = 1;
        repeat (3) @(negedge clk);
        rel_busy = 0;
        reset = 0;
        mode = 0; busy_len = 2;
        expect_cmd(0, 1, 0, 32'h600, 32'h00000066, 4'hF);
        expect_cmd(1, 1, 0, 32'h700, 32'h00000077, 4'hF);
        expect_rsp(0, 0, 0, -1);
        expect_rsp(1, 0, 0, -1);
        fork
            send(0, 1, 0, 32'h600, 32'h00000066, 4'hF);
            send(1, 1, 0, 32'h700, 32'h00000077, 4'hF);
        join
        wait_rsp();

        repeat (10) @(negedge clk);
        chk("left_req", exp_req.size(), 0);
        chk("left_gnt", exp_gnt.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
